// File: rtl/core_control_wb_arbiter_pkg.sv
// rtl/core_control_wb_arbiter_pkg.sv - shared uarch types and register numbers for writeback arbitration
package core_control_wb_arbiter_pkg;

  typedef logic [31:0] word;
  typedef logic [3:0]  reg_num;
  typedef logic [3:0]  psr_flags;

  typedef enum logic {
    SINGLE   = 1'b0,
    PAIR_2ND = 1'b1
  } wb_arb_state;

  localparam reg_num REG_LR = 4'd14;
  localparam reg_num REG_PC = 4'd15;

endpackage

// File: rtl/core_control_wb_pair.sv
// rtl/core_control_wb_pair.sv - second-write latch and PAIR_2ND state for atomic write pairs
module core_control_wb_pair
  import core_control_wb_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  reg_num      load_rd,
  input  word         load_value,
  output wb_arb_state state,
  output reg_num      pend_rd,
  output word         pend_value
);

  // PAIR_2ND always lasts exactly one cycle; reset drops any pending second write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SINGLE;
      pend_rd    <= '0;
      pend_value <= '0;
    end else begin
      case (state)
        SINGLE: begin
          if (load) begin
            state      <= PAIR_2ND;
            pend_rd    <= load_rd;
            pend_value <= load_value;
          end
        end
        PAIR_2ND: state <= SINGLE;
        default:  state <= SINGLE;
      endcase
    end
  end

endmodule

// File: rtl/core_control_wb_arbiter.sv
// rtl/core_control_wb_arbiter.sv - register-file write port arbiter (exc > mem > mul > alu, ALU aging)
// Optional forwarding comparator enabled by CORE_WB_BYPASS_EN.
module core_control_wb_arbiter
  import core_control_wb_arbiter_pkg::*;
#(
  parameter int unsigned ALU_AGE_MAX = 3
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     exc_valid,
  output logic     exc_ready,
  input  word      exc_lr,
  input  word      exc_vector,
  input  logic     mem_valid,
  output logic     mem_ready,
  input  reg_num   mem_rd,
  input  word      mem_data,
  input  logic     mul_valid,
  output logic     mul_ready,
  input  logic     mul_long,
  input  reg_num   mul_rd_lo,
  input  reg_num   mul_rd_hi,
  input  word      mul_q_lo,
  input  word      mul_q_hi,
  input  logic     alu_valid,
  output logic     alu_ready,
  input  reg_num   alu_rd,
  input  word      alu_q,
  input  logic     alu_update_flags,
  input  psr_flags alu_flags,
`ifdef CORE_WB_BYPASS_EN
  input  reg_num   fwd_ra,
  output logic     fwd_hit,
  output word      fwd_value,
`endif
  output logic     writeback,
  output reg_num   rd,
  output word      wr_value,
  output logic     update_flags,
  output psr_flags wb_flags,
  output logic     pair_busy
);

  localparam logic [1:0] AGE_MAX = 2'(ALU_AGE_MAX);

  wb_arb_state state;
  reg_num      pend_rd;
  word         pend_value;
  logic [1:0]  alu_age;
  logic        can_grant;
  logic        alu_promoted;
  logic        pair_load;
  reg_num      pair_rd;
  word         pair_value;

  assign pair_busy    = (state == PAIR_2ND);
  assign can_grant    = !rst && (state == SINGLE);
  assign alu_promoted = (alu_age == AGE_MAX);

  always_comb begin
    exc_ready = can_grant && exc_valid;
    mem_ready = can_grant && mem_valid && !exc_valid;
    mul_ready = can_grant && mul_valid && !exc_valid && !mem_valid &&
                !(alu_promoted && alu_valid);
    alu_ready = can_grant && alu_valid && !exc_valid && !mem_valid &&
                (!mul_valid || alu_promoted);
  end

  assign pair_load  = exc_ready || (mul_ready && mul_long);
  assign pair_rd    = exc_ready ? REG_PC : mul_rd_hi;
  assign pair_value = exc_ready ? exc_vector : mul_q_hi;

  core_control_wb_pair u_pair (
    .clk        (clk),
    .rst        (rst),
    .load       (pair_load),
    .load_rd    (pair_rd),
    .load_value (pair_value),
    .state      (state),
    .pend_rd    (pend_rd),
    .pend_value (pend_value)
  );

  always_ff @(posedge clk) begin
    if (rst || !alu_valid || alu_ready) begin
      alu_age <= '0;
    end else if (alu_age != AGE_MAX) begin
      alu_age <= alu_age + 2'd1;
    end
  end

  // The pending second write takes the port in PAIR_2ND; no grant can coincide with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      writeback    <= 1'b0;
      rd           <= '0;
      wr_value     <= '0;
      update_flags <= 1'b0;
      wb_flags     <= '0;
    end else begin
      writeback    <= 1'b0;
      update_flags <= 1'b0;
      if (pair_busy) begin
        writeback <= 1'b1;
        rd        <= pend_rd;
        wr_value  <= pend_value;
      end else if (exc_ready) begin
        writeback <= 1'b1;
        rd        <= REG_LR;
        wr_value  <= exc_lr;
      end else if (mem_ready) begin
        writeback <= 1'b1;
        rd        <= mem_rd;
        wr_value  <= mem_data;
      end else if (mul_ready) begin
        writeback <= 1'b1;
        rd        <= mul_rd_lo;
        wr_value  <= mul_q_lo;
      end else if (alu_ready) begin
        writeback    <= 1'b1;
        rd           <= alu_rd;
        wr_value     <= alu_q;
        update_flags <= alu_update_flags;
        wb_flags     <= alu_flags;
      end
    end
  end

`ifdef CORE_WB_BYPASS_EN
  logic cur_hit;
  logic pend_hit;

  assign cur_hit   = writeback && (rd == fwd_ra);
  assign pend_hit  = pair_busy && (pend_rd == fwd_ra);
  assign fwd_hit   = cur_hit || pend_hit;
  assign fwd_value = (!cur_hit && pend_hit) ? pend_value : wr_value;
`endif

endmodule

// File: tb/tb_core_control_wb_arbiter.sv
// tb/tb_core_control_wb_arbiter.sv - directed self-checking bench for core_control_wb_arbiter
module tb_core_control_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid, exc_ready;
  logic [31:0] exc_lr, exc_vector;
  logic        mem_valid, mem_ready;
  logic [3:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mul_valid, mul_ready, mul_long;
  logic [3:0]  mul_rd_lo, mul_rd_hi;
  logic [31:0] mul_q_lo, mul_q_hi;
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_rd;
  logic [31:0] alu_q;
  logic        alu_update_flags;
  logic [3:0]  alu_flags;
  logic        writeback;
  logic [3:0]  rd;
  logic [31:0] wr_value;
  logic        update_flags;
  logic [3:0]  wb_flags;
  logic        pair_busy;
`ifdef CORE_WB_BYPASS_EN
  logic [3:0]  fwd_ra;
  logic        fwd_hit;
  logic [31:0] fwd_value;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  core_control_wb_arbiter #(.ALU_AGE_MAX(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .exc_valid        (exc_valid),
    .exc_ready        (exc_ready),
    .exc_lr           (exc_lr),
    .exc_vector       (exc_vector),
    .mem_valid        (mem_valid),
    .mem_ready        (mem_ready),
    .mem_rd           (mem_rd),
    .mem_data         (mem_data),
    .mul_valid        (mul_valid),
    .mul_ready        (mul_ready),
    .mul_long         (mul_long),
    .mul_rd_lo        (mul_rd_lo),
    .mul_rd_hi        (mul_rd_hi),
    .mul_q_lo         (mul_q_lo),
    .mul_q_hi         (mul_q_hi),
    .alu_valid        (alu_valid),
    .alu_ready        (alu_ready),
    .alu_rd           (alu_rd),
    .alu_q            (alu_q),
    .alu_update_flags (alu_update_flags),
    .alu_flags        (alu_flags),
`ifdef CORE_WB_BYPASS_EN
    .fwd_ra           (fwd_ra),
    .fwd_hit          (fwd_hit),
    .fwd_value        (fwd_value),
`endif
    .writeback        (writeback),
    .rd               (rd),
    .wr_value         (wr_value),
    .update_flags     (update_flags),
    .wb_flags         (wb_flags),
    .pair_busy        (pair_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb(input string tag, input logic en, input logic [3:0] r, input logic [31:0] v);
    check({tag, ".writeback"}, {31'd0, writeback}, {31'd0, en});
    if (en) begin
      check({tag, ".rd"}, {28'd0, rd}, {28'd0, r});
      check({tag, ".value"}, wr_value, v);
    end
  endtask

  task automatic check_ready(input string tag, input logic [3:0] exp_eMmA);
    check(tag, {28'd0, exc_ready, mem_ready, mul_ready, alu_ready}, {28'd0, exp_eMmA});
  endtask

  initial begin
    rst = 1'b1;
    exc_valid = 1'b1; exc_lr = '0; exc_vector = '0;
    mem_valid = 1'b1; mem_rd = '0; mem_data = '0;
    mul_valid = 1'b1; mul_long = 1'b0; mul_rd_lo = '0; mul_rd_hi = '0; mul_q_lo = '0; mul_q_hi = '0;
    alu_valid = 1'b1; alu_rd = '0; alu_q = '0; alu_update_flags = 1'b0; alu_flags = '0;
`ifdef CORE_WB_BYPASS_EN
    fwd_ra = '0;
`endif
    tick();
    tick();
    check_ready("reset.ready", 4'b0000);
    check_wb("reset", 1'b0, 4'd0, 32'd0);
    check("reset.rd", {28'd0, rd}, 32'd0);
    check("reset.value", wr_value, 32'd0);
    check("reset.update_flags", {31'd0, update_flags}, 32'd0);
    check("reset.wb_flags", {28'd0, wb_flags}, 32'd0);
    check("reset.pair_busy", {31'd0, pair_busy}, 32'd0);
    exc_valid = 1'b0; mem_valid = 1'b0; mul_valid = 1'b0; alu_valid = 1'b0;
    rst = 1'b0;
    tick();

    // ALU-only back-to-back writes with flag tracking
    alu_valid = 1'b1; alu_rd = 4'd2; alu_q = 32'h22; alu_update_flags = 1'b1; alu_flags = 4'hA;
    #1 check_ready("alu1.ready", 4'b0001);
    tick();
    check_wb("alu1", 1'b1, 4'd2, 32'h22);
    check("alu1.uf", {31'd0, update_flags}, 32'd1);
    check("alu1.flags", {28'd0, wb_flags}, 32'hA);
    alu_rd = 4'd3; alu_q = 32'h33; alu_update_flags = 1'b0; alu_flags = 4'h5;
    tick();
    check_wb("alu2", 1'b1, 4'd3, 32'h33);
    check("alu2.uf", {31'd0, update_flags}, 32'd0);
    check("alu2.flags", {28'd0, wb_flags}, 32'h5);
    alu_rd = 4'd4; alu_q = 32'h44; alu_update_flags = 1'b1; alu_flags = 4'hC;
    tick();
    check_wb("alu3", 1'b1, 4'd4, 32'h44);
    check("alu3.uf", {31'd0, update_flags}, 32'd1);
    alu_valid = 1'b0; alu_flags = 4'h3;
    tick();
    check_wb("alu_idle", 1'b0, 4'd0, 32'd0);
    check("alu_idle.uf", {31'd0, update_flags}, 32'd0);
    check("alu_idle.flags_hold", {28'd0, wb_flags}, 32'hC);

    // mem and alu together: mem first, ALU next cycle
    mem_valid = 1'b1; mem_rd = 4'd5; mem_data = 32'hDEADBEEF;
    alu_valid = 1'b1; alu_rd = 4'd6; alu_q = 32'h66; alu_update_flags = 1'b0;
    #1 check_ready("memalu.ready", 4'b0100);
    tick();
    check_wb("mem", 1'b1, 4'd5, 32'hDEADBEEF);
    mem_valid = 1'b0;
    #1 check_ready("memalu.ready2", 4'b0001);
    tick();
    check_wb("alu_after_mem", 1'b1, 4'd6, 32'h66);
    alu_valid = 1'b0;
    tick();

    // Long multiply pair; payload changes after grant must not matter
    mul_valid = 1'b1; mul_long = 1'b1; mul_rd_lo = 4'd0; mul_rd_hi = 4'd1;
    mul_q_lo = 32'hFFFFFFFE; mul_q_hi = 32'h00000001;
    #1 check_ready("mul.ready", 4'b0010);
    tick();
    check_wb("mul.lo", 1'b1, 4'd0, 32'hFFFFFFFE);
    check("mul.pair_busy", {31'd0, pair_busy}, 32'd1);
`ifdef CORE_WB_BYPASS_EN
    fwd_ra = 4'd1;
    #1 check("fwd.pend_hit", {31'd0, fwd_hit}, 32'd1);
    check("fwd.pend_value", fwd_value, 32'h00000001);
    fwd_ra = 4'd0;
    #1 check("fwd.cur_value", fwd_value, 32'hFFFFFFFE);
`endif
    mul_valid = 1'b0; mul_q_hi = 32'hBAD0BAD0; mul_rd_hi = 4'd9;
    alu_valid = 1'b1; alu_rd = 4'd7; alu_q = 32'h77;
    #1 check_ready("pair2nd.ready", 4'b0000);
    tick();
    check_wb("mul.hi", 1'b1, 4'd1, 32'h00000001);
    check("mul.pair_done", {31'd0, pair_busy}, 32'd0);
    check_ready("after_pair.ready", 4'b0001);
    tick();
    check_wb("alu_after_pair", 1'b1, 4'd7, 32'h77);
    alu_valid = 1'b0;
    tick();

    // Exception raised in the PAIR_2ND cycle of a multiply
    mul_valid = 1'b1; mul_long = 1'b1; mul_rd_lo = 4'd8; mul_rd_hi = 4'd9;
    mul_q_lo = 32'h80; mul_q_hi = 32'h90;
    tick();
    check_wb("excmul.lo", 1'b1, 4'd8, 32'h80);
    mul_valid = 1'b0;
    exc_valid = 1'b1; exc_lr = 32'h1000; exc_vector = 32'h18;
    #1 check_ready("excmul.blocked", 4'b0000);
    tick();
    check_wb("excmul.hi", 1'b1, 4'd9, 32'h90);
    check_ready("excmul.exc_ready", 4'b1000);
    tick();
    check_wb("exc.r14", 1'b1, 4'd14, 32'h1000);
    check("exc.pair_busy", {31'd0, pair_busy}, 32'd1);
    exc_valid = 1'b0; exc_vector = 32'hBAD;
    tick();
    check_wb("exc.r15", 1'b1, 4'd15, 32'h18);
    tick();
    check_wb("exc.idle", 1'b0, 4'd0, 32'd0);

    // ALU starvation: promoted after exactly three refusals
    mul_valid = 1'b1; mul_long = 1'b0; mul_rd_lo = 4'd10; mul_q_lo = 32'hA0;
    alu_valid = 1'b1; alu_rd = 4'd11; alu_q = 32'hB0;
    for (int i = 0; i < 3; i++) begin
      #1 check_ready($sformatf("starve%0d.ready", i), 4'b0010);
      tick();
      check_wb($sformatf("starve%0d", i), 1'b1, 4'd10, 32'hA0);
    end
    check_ready("promote.ready", 4'b0001);
    tick();
    check_wb("promote.alu", 1'b1, 4'd11, 32'hB0);
    check_ready("demote.ready", 4'b0010);
    mul_valid = 1'b0; alu_valid = 1'b0;
    tick();
    tick();

    // Reset asserted in PAIR_2ND discards the pending hi write
    mul_valid = 1'b1; mul_long = 1'b1; mul_rd_lo = 4'd2; mul_rd_hi = 4'd3;
    mul_q_lo = 32'h20; mul_q_hi = 32'h30;
    tick();
    check_wb("rstpair.lo", 1'b1, 4'd2, 32'h20);
    mul_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("rstpair.wb", {31'd0, writeback}, 32'd0);
    check("rstpair.rd", {28'd0, rd}, 32'd0);
    check("rstpair.value", wr_value, 32'd0);
    check("rstpair.pair_busy", {31'd0, pair_busy}, 32'd0);
    check("rstpair.uf", {31'd0, update_flags}, 32'd0);
    check("rstpair.flags", {28'd0, wb_flags}, 32'd0);
    rst = 1'b0;
    tick();
    check("rstpair.no_hi", {31'd0, writeback}, 32'd0);
`ifdef CORE_WB_BYPASS_EN
    fwd_ra = 4'd3;
    #1 check("rstpair.fwd_hit", {31'd0, fwd_hit}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_control_wb_arbiter.md
# core_control_wb_arbiter

Arbitrates the core's single register-file write port among four producers: exception entry, load data return, multiplier and ALU. Grants at most one write per cycle and sequences two-write operations as atomic pairs: long multiply lo/hi, and exception R14 then R15. Drives registered writeback, destination, value and flag-update signals to the register file and PSR, with one cycle of latency from grant.

## Interface
- `ALU_AGE_MAX`, default 3: cycles an ALU request may be refused before it is promoted above the multiplier.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `exc_valid` in 1 / `exc_ready` out 1: exception entry request.
- `exc_lr` in word: return address, written to R14.
- `exc_vector` in word: vector address, written to R15.
- `mem_valid` in 1 / `mem_ready` out 1: load data return.
- `mem_rd` in reg_num: load destination register.
- `mem_data` in word: load data.
- `mul_valid` in 1 / `mul_ready` out 1: multiplier result.
- `mul_long` in 1: long multiply, writes a lo/hi pair.
- `mul_rd_lo` in reg_num, `mul_rd_hi` in reg_num: destinations of the lo and hi words.
- `mul_q_lo` in word, `mul_q_hi` in word: multiplier result words.
- `alu_valid` in 1 / `alu_ready` out 1: ALU result.
- `alu_rd` in reg_num, `alu_q` in word: ALU destination and result.
- `alu_update_flags` in 1, `alu_flags` in psr_flags: PSR flag update and flag values.
- `writeback` out 1, `rd` out reg_num, `wr_value` out word: registered register-file write.
- `update_flags` out 1, `wb_flags` out psr_flags: registered PSR flag write.
- `pair_busy` out 1: high while the second write of a pair is pending.

## Operation
- Handshake: a transfer occurs on `valid && ready`. Payload must stay stable while `valid` is high and `ready` is low.
- `*_ready` is combinational from the valids and state. At most one `ready` is high per cycle. All `ready` outputs are low in state PAIR_2ND.
- FSM states:
  - SINGLE: grant by priority exc > mem > mul > alu.
  - SINGLE, ALU promoted: when `alu_age == ALU_AGE_MAX`, priority becomes exc > mem > alu > mul.
  - SINGLE → PAIR_2ND: on an exc grant, or on a mul grant with `mul_long`.
  - PAIR_2ND → SINGLE: unconditionally after one cycle. The captured second write (hi word, or R15 vector) is issued then.
- Pair contents:
  - Exception: first write is R14 ← `exc_lr`, second is R15 ← `exc_vector`.
  - Long multiply: first write is `mul_rd_lo` ← `mul_q_lo`, second is `mul_rd_hi` ← `mul_q_hi`.
  - Second-write rd and value are latched at grant. Requesters may deassert or change their payload afterwards.
- `alu_age` counter:
  - 2-bit, saturating at `ALU_AGE_MAX`.
  - Increments on cycles with `alu_valid && !alu_ready`.
  - Clears on an ALU grant or when `alu_valid` is low.
- Flags: `update_flags` is asserted only for an ALU grant with `alu_update_flags`. `wb_flags` is loaded with `alu_flags` on every ALU grant and holds otherwise.
- Same-register writes in one cycle cannot occur: the port is single. Ordering between requesters is the issuing logic's responsibility.

## Timing
- Latency: grant in cycle N produces `writeback`/`rd`/`wr_value` valid in cycle N+1 for exactly one cycle.
- The second write of a pair appears in cycle N+2. Between grants there are no bubbles: a new grant in the PAIR_2ND cycle is impossible, so the next single write appears at N+3 at the earliest.
- Exception arriving during PAIR_2ND of a multiply: the hi write completes first, and the exception is granted in the following cycle.
- Reset values:
  - State = SINGLE, `alu_age` = 0.
  - `writeback`, `update_flags`, `pair_busy` = 0.
  - `rd` = 0, `wr_value` = 0, `wb_flags` = 0.
  - All `ready` outputs = 0 during the reset cycle.
- Reset asserted in PAIR_2ND: the pending second write is discarded, and no write is issued in the cycle after reset.
- No request is ever dropped: a refused valid remains pending until it is granted.

## Configuration
- `CORE_WB_BYPASS_EN` defined:
  - Adds input `fwd_ra` (reg_num) and outputs `fwd_hit` (1) and `fwd_value` (word).
  - `fwd_hit` = `writeback && rd == fwd_ra`, combinationally; `fwd_value` = `wr_value`.
  - A pending PAIR_2ND write also hits, against its latched rd and value, with lower precedence than the current write.
- `CORE_WB_BYPASS_EN` undefined: these three ports do not exist, and no comparator logic is built.

## Structure
- The `word`, `reg_num` and `psr_flags` types, plus an `wb_arb_state` enum (SINGLE, PAIR_2ND), belong in the shared uarch package.
- R14/R15 register numbers come from the existing shared defines.
- One natural sub-module: `core_control_wb_pair`, which holds the second-write latch and the PAIR_2ND flag.

## Test plan
- ALU-only load: `alu_valid` for 3 cycles with rd=2, 3, 4 → three back-to-back writes in cycles +1..+3. `update_flags` tracks `alu_update_flags`.
- mem+alu simultaneous: mem rd=5 data=0xDEADBEEF granted first → ALU written one cycle later; `alu_age` reaches 1 then clears.
- Long multiply: rd_lo=0, rd_hi=1, q=0x00000001_FFFFFFFE → r0=0xFFFFFFFE at N+1, r1=0x00000001 at N+2, `pair_busy` high at N+1.
- Exception during mul pair: exc raised in the PAIR_2ND cycle → hi write first, then R14=lr, then R15=vector on consecutive cycles.
- ALU starvation: continuous mul requests plus `alu_valid` → ALU is granted after exactly `ALU_AGE_MAX`=3 refusals.
- Reset mid-pair: assert `rst` in the PAIR_2ND cycle → no hi write appears, and all outputs are 0 the next cycle. With `CORE_WB_BYPASS_EN`, `fwd_hit` is low afterwards.
